// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and frame/baud helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Clock cycles from txd falling to tx_busy falling.
  function automatic int unsigned frame_clks(input int unsigned clks_per_bit,
                                             input int unsigned data_bits,
                                             input int unsigned parity_en,
                                             input int unsigned stop_bits);
    return clks_per_bit * (1 + data_bits + parity_en + stop_bits);
  endfunction

  // Rounded to the nearest whole cycle.
  function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq,
                                                    input int unsigned baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

  localparam int unsigned DEFAULT_FRAME_CLKS = frame_clks(434, 8, 0, 1);

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: bit_end marks the last clk of each CLKS_PER_BIT period.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic bit_end
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign bit_end = enable && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= bit_end ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops one byte from the TX FIFO per frame and
// sends start, LSB-first data, optional parity and stop bits on txd.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_clear_req,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       txd
);

  localparam logic [7:0] DATA_MASK = 8'((1 << DATA_BITS) - 1);
  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic       ODD       = (PARITY_ODD != 0);

  tx_state_t  state, state_nxt;
  logic [7:0] shift, shift_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic       parity, parity_nxt;
  logic       txd_nxt, busy_nxt, clr_nxt, done_nxt;
  logic       bit_end;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == IDLE),
    .enable (state != IDLE),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      shift        <= '0;
      bit_cnt      <= '0;
      parity       <= 1'b0;
      txd          <= 1'b1;
      tx_busy      <= 1'b0;
      tx_clear_req <= 1'b0;
      tx_done      <= 1'b0;
    end else begin
      state        <= state_nxt;
      shift        <= shift_nxt;
      bit_cnt      <= bit_cnt_nxt;
      parity       <= parity_nxt;
      txd          <= txd_nxt;
      tx_busy      <= busy_nxt;
      tx_clear_req <= clr_nxt;
      tx_done      <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift;
    bit_cnt_nxt = bit_cnt;
    parity_nxt  = parity;
    txd_nxt     = txd;
    busy_nxt    = tx_busy;
    clr_nxt     = 1'b0;
    done_nxt    = 1'b0;

    case (state)
      IDLE: begin
        txd_nxt  = 1'b1;
        busy_nxt = 1'b0;
        if (tx_start) begin
          // Parity is taken at acceptance since the shift register is consumed.
          shift_nxt  = tx_data & DATA_MASK;
          parity_nxt = (^(tx_data & DATA_MASK)) ^ ODD;
          clr_nxt    = 1'b1;
          busy_nxt   = 1'b1;
          txd_nxt    = 1'b0;
          state_nxt  = START;
        end
      end
      START: begin
        if (bit_end) begin
          txd_nxt     = shift[0];
          bit_cnt_nxt = '0;
          state_nxt   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt < LAST_DATA) begin
            shift_nxt   = shift >> 1;
            txd_nxt     = shift[1];
            bit_cnt_nxt = bit_cnt + 3'd1;
          end else if (PARITY_EN != 0) begin
            txd_nxt   = parity;
            state_nxt = PARITY;
          end else begin
            txd_nxt     = 1'b1;
            bit_cnt_nxt = '0;
            state_nxt   = STOP;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          txd_nxt     = 1'b1;
          bit_cnt_nxt = '0;
          state_nxt   = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_cnt == LAST_STOP) begin
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: four configurations at CLKS_PER_BIT=4.
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start [4];
  logic [7:0] data  [4];
  logic       clr   [4];
  logic       busy  [4];
  logic       done  [4];
  logic       txd   [4];

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  // 0: 8N1   1: 8E1   2: 8O1   3: 7N2
  uart_tx_serializer #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst(rst), .tx_data(data[0]), .tx_start(start[0]),
    .tx_clear_req(clr[0]), .tx_busy(busy[0]), .tx_done(done[0]), .txd(txd[0]));
  uart_tx_serializer #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_b (
    .clk(clk), .rst(rst), .tx_data(data[1]), .tx_start(start[1]),
    .tx_clear_req(clr[1]), .tx_busy(busy[1]), .tx_done(done[1]), .txd(txd[1]));
  uart_tx_serializer #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_c (
    .clk(clk), .rst(rst), .tx_data(data[2]), .tx_start(start[2]),
    .tx_clear_req(clr[2]), .tx_busy(busy[2]), .tx_done(done[2]), .txd(txd[2]));
  uart_tx_serializer #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_d (
    .clk(clk), .rst(rst), .tx_data(data[3]), .tx_start(start[3]),
    .tx_clear_req(clr[3]), .tx_busy(busy[3]), .tx_done(done[3]), .txd(txd[3]));

  task automatic chk(input int i, input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL u%0d %s: got %0h expected %0h at %0t", i, tag, obs, exp, $time);
  endtask

  task automatic chk_idle(input int i, input string tag);
    chk(i, {tag, " txd"}, txd[i], 1'b1);
    chk(i, {tag, " busy"}, busy[i], 1'b0);
    chk(i, {tag, " clr"}, clr[i], 1'b0);
    chk(i, {tag, " done"}, done[i], 1'b0);
  endtask

  // Entered one negedge before the accepting posedge; returns at the negedge
  // right after tx_busy should have fallen. bits[k] is frame bit k.
  task automatic frame(input int i, input logic [15:0] bits, input int nbits, input bit drop);
    int n;
    n = nbits * 4;
    @(negedge clk);
    for (int c = 0; c < n; c++) begin
      chk(i, $sformatf("txd c%0d", c), txd[i], bits[c / 4]);
      chk(i, $sformatf("busy c%0d", c), busy[i], 1'b1);
      chk(i, $sformatf("clr c%0d", c), clr[i], (c == 0));
      chk(i, $sformatf("done c%0d", c), done[i], 1'b0);
      if (c == 0) begin
        if (drop) start[i] = 1'b0;
        data[i] = ~data[i];
      end
      @(negedge clk);
    end
    chk(i, "end busy", busy[i], 1'b0);
    chk(i, "end done", done[i], 1'b1);
    chk(i, "end txd", txd[i], 1'b1);
    chk(i, "end clr", clr[i], 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start[i] = 1'b0;
      data[i]  = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) chk_idle(i, "reset");
    rst = 1'b0;

    // Idle hygiene
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      chk_idle(0, "idle");
    end

    // Basic 8N1 frame, 0xA5
    start[0] = 1'b1; data[0] = 8'hA5;
    frame(0, 16'b1101001010, 10, 1'b1);

    // Even and odd parity, 0xA5 has four ones
    start[1] = 1'b1; data[1] = 8'hA5;
    frame(1, 16'b10101001010, 11, 1'b1);
    start[2] = 1'b1; data[2] = 8'hA5;
    frame(2, 16'b11101001010, 11, 1'b1);

    // 7 data bits, 2 stop bits; bit 7 never reaches the line
    start[3] = 1'b1; data[3] = 8'hFF;
    frame(3, 16'b1111111110, 10, 1'b1);
    @(negedge clk);
    start[3] = 1'b1; data[3] = 8'h80;
    frame(3, 16'b1100000000, 10, 1'b1);

    // Held start: three back-to-back frames
    @(negedge clk);
    start[0] = 1'b1; data[0] = 8'h00;
    frame(0, 16'b1000000000, 10, 1'b0);
    data[0] = 8'hFF;
    frame(0, 16'b1111111110, 10, 1'b0);
    data[0] = 8'h3C;
    frame(0, 16'b1001111000, 10, 1'b0);
    start[0] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk_idle(0, "after held");
    end

    // Reset during data bit 3 (cycles 16..19 after acceptance)
    start[0] = 1'b1; data[0] = 8'hA5;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (17) @(negedge clk);
    chk(0, "pre-rst busy", busy[0], 1'b1);
    rst = 1'b1;
    #1;
    chk(0, "async rst txd", txd[0], 1'b1);
    chk(0, "async rst busy", busy[0], 1'b0);
    @(negedge clk);
    chk_idle(0, "in rst");
    rst = 1'b0;
    @(negedge clk);
    start[0] = 1'b1; data[0] = 8'h3C;
    frame(0, 16'b1001111000, 10, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- UART transmit serializer that sits directly downstream of the TX FIFO.
- Accepts one byte per start/clear handshake and serializes it onto txd, LSB first, as start, data, optional parity, then stop bits.
- Holds busy for the whole frame. Any start seen while busy is ignored.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per bit period (50 MHz / 115200); legal range ≥2.
- DATA_BITS, 8, data bits per frame; legal range 5..8.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; one clock domain; asynchronous, active-high
- tx_data  input  8  byte from the FIFO head; bits above DATA_BITS-1 are ignored
- tx_start  input  1  FIFO has data; level signal
- tx_clear_req  output  1  one-cycle pulse; tells the FIFO to pop the head entry
- tx_busy  output  1  frame in progress
- tx_done  output  1  one-cycle pulse at the end of the last stop bit
- txd  output  1  serial line; idles high

Behaviour:
- Reset (async, while rst=1):
  - txd=1; tx_busy, tx_clear_req, tx_done = 0.
  - State IDLE; shift register, baud counter and bit counter = 0.
  - A reset mid-frame aborts the frame immediately; the line returns high with no partial stop bit.
- All outputs are registered.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - txd=1, tx_busy=0.
  - On an edge with tx_start=1: latch tx_data into the shift register, tx_clear_req<=1 for exactly one cycle, tx_busy<=1, txd<=0, baud_cnt<=0, state<=START.
  - Latency: txd falls 1 cycle after tx_start is sampled high.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1; bit_end = (baud_cnt==CLKS_PER_BIT-1).
  - Reloads to 0 on bit_end.
  - Each bit is held for exactly CLKS_PER_BIT cycles.
- START: on bit_end, txd<=shift[0], bit_cnt<=0, state<=DATA.
- DATA:
  - On bit_end, if bit_cnt<DATA_BITS-1: shift right, txd<=next bit, bit_cnt++.
  - Otherwise go to PARITY (PARITY_EN=1) or STOP, driving txd accordingly.
  - Parity bit = XOR of the DATA_BITS latched bits, XOR PARITY_ODD.
- PARITY: one bit period, then STOP with txd<=1.
- STOP:
  - txd=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - At the end: state<=IDLE, tx_busy<=0, tx_done<=1 for one cycle.
- Frame length from txd falling to tx_busy falling = CLKS_PER_BIT*(1+DATA_BITS+PARITY_EN+STOP_BITS) cycles.
- tx_start while tx_busy=1 is ignored. The FIFO keeps tx_start asserted; the next frame begins on the first IDLE-cycle edge.
- Back-to-back frames: the line stays high for exactly the stop period plus one IDLE cycle.
- tx_clear_req is asserted at most once per frame.
- tx_data is sampled only on the IDLE→START edge; later changes on tx_data do not affect the frame in flight.
- tx_start dropping low after acceptance has no effect.

Decomposition:
- Shared package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - localparam for the frame length;
  - function computing CLKS_PER_BIT from CLK_FREQ and BAUD.
- One sub-module: uart_baud_tick.
  - Bit-period counter with clear and enable inputs and a bit_end output.
  - Reused by the future RX deserializer.
- The serializer FSM and shift register stay in the top module.

Test Plan:
- Basic frame: CLKS_PER_BIT=4, tx_data=0xA5, tx_start pulse.
  - tx_clear_req high exactly 1 cycle, 1 cycle after start.
  - txd = 0,1,0,1,0,0,1,0,1,1, each bit for 4 cycles.
  - tx_busy high 40 cycles; tx_done pulses once.
- Parity: PARITY_EN=1, 0xA5 → parity bit 0 (even) and 1 with PARITY_ODD=1; frame is 44 cycles.
- Held start: tx_start held high for 3 frames with data 0x00, 0xFF, 0x3C.
  - Exactly 3 tx_clear_req pulses.
  - Each frame starts 1 cycle after the previous tx_busy falls.
  - tx_data changes mid-frame do not corrupt the bits on txd.
- Config and reset:
  - STOP_BITS=2, DATA_BITS=7, tx_data=0xFF → 7 data ones (bit7 ignored), stop high 8 cycles.
  - rst asserted during DATA bit 3 → txd=1, tx_busy=0 asynchronously; next frame after reset is correct.
- Idle hygiene: tx_start=0 for 100 cycles → txd stays 1; tx_clear_req, tx_busy and tx_done stay 0.
